// File: rtl/store_buffer_pkg.sv
// Shared definitions for the store buffer: default depth, entry field
// widths, the entry record and the lane-merge helper.
// Optional feature macro: STORE_BUFFER_MERGE_EN (store merging into tail-1).
package store_buffer_pkg;

    localparam int SB_DEPTH_DEFAULT = 4;
    localparam int SB_CNT_W_DEFAULT = 3;
    localparam int SB_WADDR_W       = 30;
    localparam int SB_BEN_W         = 4;
    localparam int SB_DATA_W        = 32;

    typedef struct packed {
        logic [SB_WADDR_W-1:0] waddr;
        logic [SB_BEN_W-1:0]   ben;
        logic [SB_DATA_W-1:0]  data;
    } sb_entry_t;

    // Overwrite only the byte lanes selected by ben, keep the others.
    function automatic logic [SB_DATA_W-1:0] sb_merge_lanes(
        input logic [SB_DATA_W-1:0] old_data,
        input logic [SB_DATA_W-1:0] new_data,
        input logic [SB_BEN_W-1:0]  ben
    );
        logic [SB_DATA_W-1:0] res;
        res = old_data;
        for (int l = 0; l < SB_BEN_W; l++) begin
            if (ben[l]) begin
                res[8*l +: 8] = new_data[8*l +: 8];
            end
        end
        return res;
    endfunction

endpackage

// File: rtl/sb_fifo_ctrl.sv
// Head/tail pointer and occupancy management for the store buffer.
// A push that merges into an existing entry does not allocate a slot.
module sb_fifo_ctrl
    import store_buffer_pkg::*;
#(
    parameter int DEPTH = SB_DEPTH_DEFAULT,
    parameter int CNT_W = SB_CNT_W_DEFAULT,
    parameter int PTR_W = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             push,
    input  logic             pop,
    input  logic             merge,
    output logic [PTR_W-1:0] head,
    output logic [PTR_W-1:0] tail,
    output logic [CNT_W-1:0] count
);

    logic             alloc_s;
    logic [PTR_W-1:0] head_r;
    logic [PTR_W-1:0] tail_r;
    logic [CNT_W-1:0] count_r;

    assign alloc_s = push && !merge;

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            head_r  <= {PTR_W{1'b0}};
            tail_r  <= {PTR_W{1'b0}};
            count_r <= {CNT_W{1'b0}};
        end else begin
            if (alloc_s) begin
                tail_r <= tail_r + PTR_W'(1);
            end
            if (pop) begin
                head_r <= head_r + PTR_W'(1);
            end
            case ({alloc_s, pop})
                2'b10:   count_r <= count_r + CNT_W'(1);
                2'b01:   count_r <= count_r - CNT_W'(1);
                default: count_r <= count_r;
            endcase
        end
    end

    assign head  = head_r;
    assign tail  = tail_r;
    assign count = count_r;

endmodule

// File: rtl/store_buffer.sv
// Post-MEM store buffer: a small circular FIFO of pending word stores that
// drains to the memory bus one entry per cycle and flags loads that hit a
// pending store word.
// Optional feature macro: STORE_BUFFER_MERGE_EN -- a store to the same word
// as the youngest non-head entry is merged into it instead of allocating.
module store_buffer
    import store_buffer_pkg::*;
#(
    parameter int DEPTH = SB_DEPTH_DEFAULT,
    parameter int CNT_W = SB_CNT_W_DEFAULT
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             st_valid,
    input  logic [31:0]      st_addr,
    input  logic [3:0]       st_byteEn,
    input  logic [31:0]      st_wdata,
    output logic             st_ready,
    input  logic [31:0]      ld_addr,
    input  logic             ld_valid,
    output logic             ld_hit,
    output logic             bus_req,
    output logic [31:0]      bus_addr,
    output logic [3:0]       bus_byteEn,
    output logic [31:0]      bus_wdata,
    input  logic             bus_ack,
    output logic             empty,
    output logic [CNT_W-1:0] count
);

    localparam int PTR_W = $clog2(DEPTH);

    sb_entry_t        entry_r [DEPTH];
    logic [DEPTH-1:0] valid_r;

    logic [PTR_W-1:0]      head_s;
    logic [PTR_W-1:0]      tail_s;
    logic [CNT_W-1:0]      count_s;
    logic [SB_WADDR_W-1:0] st_waddr_s;
    logic                  empty_s;
    logic                  merge_ok_s;
    logic                  accept_s;
    logic                  push_s;
    logic                  merge_s;
    logic                  alloc_s;
    logic                  pop_s;
    logic                  hit_s;
    logic                  unused_s;

    assign st_waddr_s = st_addr[31:2];
    assign unused_s   = ^{st_addr[1:0], ld_addr[1:0]};

    assign empty_s  = (count_s == {CNT_W{1'b0}});
    assign st_ready = (count_s != CNT_W'(DEPTH)) || merge_ok_s;
    assign accept_s = st_valid && st_ready;
    // An all-lanes-off store completes the handshake but writes nothing.
    assign push_s   = accept_s && (st_byteEn != 4'b0000);
    assign pop_s    = !empty_s && bus_ack;
    assign alloc_s  = push_s && !merge_s;

`ifdef STORE_BUFFER_MERGE_EN
    logic [PTR_W-1:0] tail_m1_s;

    assign tail_m1_s = tail_s - PTR_W'(1);
    // count >= 2 keeps tail-1 away from the head, whose data may be on the bus.
    assign merge_ok_s = (count_s >= CNT_W'(2)) &&
                        (entry_r[tail_m1_s].waddr == st_waddr_s);
    assign merge_s    = push_s && merge_ok_s;
`else
    assign merge_ok_s = 1'b0;
    assign merge_s    = 1'b0;
`endif

    sb_fifo_ctrl #(
        .DEPTH (DEPTH),
        .CNT_W (CNT_W),
        .PTR_W (PTR_W)
    ) u_ctrl (
        .clk     (clk),
        .reset_n (reset_n),
        .push    (push_s),
        .pop     (pop_s),
        .merge   (merge_s),
        .head    (head_s),
        .tail    (tail_s),
        .count   (count_s)
    );

    // Entry storage: allocate at tail, retire at head, optionally merge at tail-1.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            valid_r <= {DEPTH{1'b0}};
            for (int i = 0; i < DEPTH; i++) begin
                entry_r[i] <= '0;
            end
        end else begin
            if (pop_s) begin
                valid_r[head_s] <= 1'b0;
            end
            if (alloc_s) begin
                entry_r[tail_s].waddr <= st_waddr_s;
                entry_r[tail_s].ben   <= st_byteEn;
                entry_r[tail_s].data  <= st_wdata;
                valid_r[tail_s]       <= 1'b1;
            end
`ifdef STORE_BUFFER_MERGE_EN
            if (merge_s) begin
                entry_r[tail_m1_s].ben  <= entry_r[tail_m1_s].ben | st_byteEn;
                entry_r[tail_m1_s].data <= sb_merge_lanes(entry_r[tail_m1_s].data,
                                                          st_wdata, st_byteEn);
            end
`endif
        end
    end

    // Word-address match of the load against every valid registered entry.
    always_comb begin
        hit_s = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            if (valid_r[i] && (entry_r[i].waddr == ld_addr[31:2])) begin
                hit_s = 1'b1;
            end else begin
                hit_s = hit_s;
            end
        end
    end

    assign ld_hit     = ld_valid && hit_s;
    assign bus_req    = !empty_s;
    assign bus_addr   = {entry_r[head_s].waddr, 2'b00};
    assign bus_byteEn = entry_r[head_s].ben;
    assign bus_wdata  = entry_r[head_s].data;
    assign empty      = empty_s;
    assign count      = count_s;

endmodule

// File: tb/tb_store_buffer.sv
// Scoreboard bench for store_buffer: accepted stores push their expected bus
// transfer into a queue; a monitor pops and compares on every bus handshake.
module tb_store_buffer;

`ifdef STORE_BUFFER_MERGE_EN
    localparam bit MERGE = 1'b1;
`else
    localparam bit MERGE = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        reset_n;
    logic        st_valid;
    logic [31:0] st_addr;
    logic [3:0]  st_byteEn;
    logic [31:0] st_wdata;
    logic        st_ready;
    logic [31:0] ld_addr;
    logic        ld_valid;
    logic        ld_hit;
    logic        bus_req;
    logic [31:0] bus_addr;
    logic [3:0]  bus_byteEn;
    logic [31:0] bus_wdata;
    logic        bus_ack;
    logic        empty;
    logic [2:0]  count;

    typedef struct {
        logic [31:0] addr;
        logic [3:0]  ben;
        logic [31:0] data;
    } exp_t;

    exp_t sb_q[$];
    int   n_vec = 0;
    int   n_err = 0;

    store_buffer #(.DEPTH(4), .CNT_W(3)) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .st_valid   (st_valid),
        .st_addr    (st_addr),
        .st_byteEn  (st_byteEn),
        .st_wdata   (st_wdata),
        .st_ready   (st_ready),
        .ld_addr    (ld_addr),
        .ld_valid   (ld_valid),
        .ld_hit     (ld_hit),
        .bus_req    (bus_req),
        .bus_addr   (bus_addr),
        .bus_byteEn (bus_byteEn),
        .bus_wdata  (bus_wdata),
        .bus_ack    (bus_ack),
        .empty      (empty),
        .count      (count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: actual 0x%08h required 0x%08h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Monitor: every bus handshake must match the oldest expected transfer.
    always @(negedge clk) begin : mon
        exp_t e;
        if (reset_n && bus_req && bus_ack) begin
            if (sb_q.size() == 0) begin
                n_vec++;
                n_err++;
                $display("FAIL bus_extra: actual transfer 0x%08h required none", bus_addr);
            end else begin
                e = sb_q.pop_front();
                chk("bus_addr", bus_addr, e.addr);
                chk("bus_byteEn", {28'd0, bus_byteEn}, {28'd0, e.ben});
                chk("bus_wdata", bus_wdata, e.data);
            end
        end
    end

    task automatic store(input logic [31:0] a, input logic [3:0] be, input logic [31:0] d,
                         input logic exp_rdy, input logic ack, input logic exp_merge);
        exp_t e;
        @(posedge clk);
        #1;
        st_valid  = 1'b1;
        st_addr   = a;
        st_byteEn = be;
        st_wdata  = d;
        bus_ack   = ack;
        @(negedge clk);
        chk("st_ready", {31'd0, st_ready}, {31'd0, exp_rdy});
        if (exp_rdy && (be != 4'b0000)) begin
            if (exp_merge) begin
                e = sb_q[sb_q.size()-1];
                e.ben = e.ben | be;
                for (int l = 0; l < 4; l++) begin
                    if (be[l]) e.data[8*l +: 8] = d[8*l +: 8];
                end
                sb_q[sb_q.size()-1] = e;
            end else begin
                e.addr = {a[31:2], 2'b00};
                e.ben  = be;
                e.data = d;
                sb_q.push_back(e);
            end
        end
        @(posedge clk);
        #1;
        st_valid = 1'b0;
    endtask

    task automatic drain();
        @(posedge clk);
        #1;
        bus_ack = 1'b1;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (empty) break;
        end
        @(posedge clk);
        #1;
        bus_ack = 1'b0;
        chk("drain_empty", {31'd0, empty}, 32'd1);
    endtask

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: actual still running required finished");
        $fatal(1, "timeout");
    end

    initial begin : stim
        reset_n   = 1'b0;
        st_valid  = 1'b0;
        st_addr   = 32'd0;
        st_byteEn = 4'b0000;
        st_wdata  = 32'd0;
        ld_addr   = 32'h0000_0000;
        ld_valid  = 1'b1;
        bus_ack   = 1'b0;

        // Reset state
        #12;
        chk("rst_bus_req", {31'd0, bus_req}, 32'd0);
        chk("rst_empty", {31'd0, empty}, 32'd1);
        chk("rst_count", {29'd0, count}, 32'd0);
        chk("rst_st_ready", {31'd0, st_ready}, 32'd1);
        chk("rst_ld_hit", {31'd0, ld_hit}, 32'd0);
        ld_valid = 1'b0;
        @(posedge clk);
        #1;
        reset_n = 1'b1;

        // Single store, bus always acking
        store(32'h0000_0104, 4'b1100, 32'hBEEF_0000, 1'b1, 1'b1, 1'b0);
        @(negedge clk);
        chk("single_bus_req", {31'd0, bus_req}, 32'd1);
        @(negedge clk);
        chk("single_empty", {31'd0, empty}, 32'd1);
        @(posedge clk);
        #1;
        bus_ack = 1'b0;

        // Fill to full with bus stalled
        store(32'h0000_0300, 4'b1111, 32'h3000_0000, 1'b1, 1'b0, 1'b0);
        store(32'h0000_0310, 4'b0011, 32'h0000_3110, 1'b1, 1'b0, 1'b0);
        store(32'h0000_0320, 4'b1000, 32'h3200_0000, 1'b1, 1'b0, 1'b0);
        store(32'h0000_0330, 4'b0100, 32'h0033_0000, 1'b1, 1'b0, 1'b0);
        store(32'h0000_0340, 4'b1111, 32'h3400_0000, 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        chk("full_count", {29'd0, count}, 32'd4);
        // One ack while full: st_ready stays low in that cycle
        @(posedge clk);
        #1;
        bus_ack = 1'b1;
        @(negedge clk);
        chk("full_ack_st_ready", {31'd0, st_ready}, 32'd0);
        @(posedge clk);
        #1;
        bus_ack = 1'b0;
        @(negedge clk);
        chk("after_pop_count", {29'd0, count}, 32'd3);
        chk("after_pop_st_ready", {31'd0, st_ready}, 32'd1);
        // Simultaneous push and pop keeps count
        store(32'h0000_0350, 4'b0001, 32'h0000_0051, 1'b1, 1'b1, 1'b0);
        @(negedge clk);
        chk("push_pop_count", {29'd0, count}, 32'd3);
        drain();

        // Load hit detection against a pending word
        store(32'h0000_0200, 4'b1111, 32'h1234_5678, 1'b1, 1'b0, 1'b0);
        ld_valid = 1'b1;
        ld_addr  = 32'h0000_0203;
        #1;
        chk("ld_hit_same_word", {31'd0, ld_hit}, 32'd1);
        ld_addr = 32'h0000_0204;
        #1;
        chk("ld_hit_next_word", {31'd0, ld_hit}, 32'd0);
        ld_addr  = 32'h0000_0200;
        ld_valid = 1'b0;
        #1;
        chk("ld_hit_no_valid", {31'd0, ld_hit}, 32'd0);
        drain();

        // Empty byte-enable completes but is not enqueued
        store(32'h0000_0800, 4'b1111, 32'h8888_8888, 1'b1, 1'b0, 1'b0);
        store(32'h0000_0804, 4'b0000, 32'hDEAD_DEAD, 1'b1, 1'b0, 1'b0);
        @(negedge clk);
        chk("zero_ben_count", {29'd0, count}, 32'd1);
        drain();

        // Merge into tail-1 (only when merging is built in)
        store(32'h0000_0010, 4'b1111, 32'h1122_3344, 1'b1, 1'b0, 1'b0);
        store(32'h0000_0020, 4'b0010, 32'h0000_BB00, 1'b1, 1'b0, 1'b0);
        store(32'h0000_0020, 4'b0001, 32'h0000_00AA, 1'b1, 1'b0, MERGE);
        @(negedge clk);
        chk("merge_count", {29'd0, count}, MERGE ? 32'd2 : 32'd3);
        drain();
        // Same word as the head never merges
        store(32'h0000_0030, 4'b0001, 32'h0000_0001, 1'b1, 1'b0, 1'b0);
        store(32'h0000_0030, 4'b0010, 32'h0000_0200, 1'b1, 1'b0, 1'b0);
        @(negedge clk);
        chk("head_nomerge_count", {29'd0, count}, 32'd2);
        drain();

        // Asynchronous reset with pending entries and bus_req high
        store(32'h0000_0600, 4'b1111, 32'h6000_0000, 1'b1, 1'b0, 1'b0);
        store(32'h0000_0610, 4'b1111, 32'h6100_0000, 1'b1, 1'b0, 1'b0);
        store(32'h0000_0620, 4'b1111, 32'h6200_0000, 1'b1, 1'b0, 1'b0);
        @(negedge clk);
        chk("pre_rst_count", {29'd0, count}, 32'd3);
        #2;
        reset_n = 1'b0;
        #1;
        chk("async_rst_bus_req", {31'd0, bus_req}, 32'd0);
        chk("async_rst_count", {29'd0, count}, 32'd0);
        chk("async_rst_empty", {31'd0, empty}, 32'd1);
        sb_q.delete();
        @(posedge clk);
        #1;
        reset_n = 1'b1;
        store(32'h0000_0700, 4'b0110, 32'h0077_7700, 1'b1, 1'b1, 1'b0);
        drain();

        chk("scoreboard_left", sb_q.size(), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
